stim_pulse_gen: RTL

- Downstream consumer of the detector's `stimulation` decision.
- Converts the decision into charge-balanced biphasic current-pulse trains: cathodic phase, interphase gap, anodic phase.
- Enforces pulse timing, pulses per train and a post-train refractory lockout.
- Sits between the seizure-detection datapath and the analog stimulator front-end (DAC/switch control).

---
 rtl/stim_pulse_gen.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/stim_pulse_gen.sv
// stim_pulse_gen: turns the detector's stimulation decision into biphasic,
// charge-balanced current-pulse trains (cathodic, gap, anodic), with a fixed
// repetition period, a pulse count per train and a post-train lockout.
// Optional build macro STIM_TRAIN_LIMIT_EN: caps the number of completed
// trains at MAX_TRAINS; once reached, stimulation is ignored until rst.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for en=0 and stimulation=1; all drives off
// CATH    | cathodic phase, amp_out = latched amplitude
// GAP     | interphase gap, all drives off
// ANOD    | anodic phase, amp_out = latched amplitude
// REST    | drives off until the pulse period has elapsed
// REFRACT | post-train lockout, stimulation ignored
module stim_pulse_gen #(
   parameter int PHASE_CYCLES     = 100,
   parameter int GAP_CYCLES       = 20,
   parameter int PERIOD_CYCLES    = 1000,
   parameter int PULSES_PER_TRAIN = 10,
   parameter int REFRACT_CYCLES   = 50000,
   parameter int AMP_WIDTH        = 8,
   parameter int MAX_TRAINS       = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 stimulation,
   input  logic [AMP_WIDTH-1:0] amp_in,
   output logic                 cathodic,
   output logic                 anodic,
   output logic [AMP_WIDTH-1:0] amp_out,
   output logic                 busy,
   output logic                 train_done,
   output logic [7:0]           pulse_idx,
   output logic                 lockout
);

   localparam int PW      = $clog2(PERIOD_CYCLES) + 1;
   localparam int TMAX_PG = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
   localparam int TMAX    = (TMAX_PG > REFRACT_CYCLES) ? TMAX_PG : REFRACT_CYCLES;
   localparam int TW      = $clog2(TMAX) + 1;

   localparam logic [TW-1:0] PHASE_LD  = TW'(PHASE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD    = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TW-1:0] REFR_LD   = TW'((REFRACT_CYCLES > 0) ? REFRACT_CYCLES - 1 : 0);
   localparam logic [PW-1:0] PERIOD_TC = PW'(PERIOD_CYCLES - 1);
   localparam logic [7:0]    LAST_IDX  = 8'(PULSES_PER_TRAIN - 1);

   // Illegal parameter sets stop elaboration instead of building broken timing.
   if (PHASE_CYCLES < 1 || PULSES_PER_TRAIN < 1 || PULSES_PER_TRAIN > 256 ||
       PERIOD_CYCLES < 1 || MAX_TRAINS < 1 || MAX_TRAINS > 255) begin : g_param_err
      $error("stim_pulse_gen: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CATH,
      S_GAP,
      S_ANOD,
      S_REST,
      S_REFRACT
   } state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          timer_q;
   logic [PW-1:0]          period_q;
   logic [AMP_WIDTH-1:0]   amp_q;
   logic [7:0]             idx_q;
   logic                   stop_q;

   logic timer_tc;
   logic period_done;
   logic abort;
   logic start_train;
   logic next_pulse;

   assign timer_tc    = (timer_q == '0);
   assign period_done = (period_q >= PERIOD_TC);
   // A disable seen at any point of the current pulse ends the train after ANOD.
   assign abort       = stop_q | en;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode and Moore outputs.
   always_comb begin
      state_d     = state_q;
      start_train = 1'b0;
      next_pulse  = 1'b0;
      train_done  = 1'b0;
      cathodic    = 1'b0;
      anodic      = 1'b0;
      amp_out     = '0;
      busy        = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (!en && stimulation && !lockout) begin
               state_d     = S_CATH;
               start_train = 1'b1;
            end
         end
         S_CATH: begin
            cathodic = 1'b1;
            amp_out  = amp_q;
            if (timer_tc) state_d = (GAP_CYCLES > 0) ? S_GAP : S_ANOD;
         end
         S_GAP: begin
            if (timer_tc) state_d = S_ANOD;
         end
         S_ANOD: begin
            anodic  = 1'b1;
            amp_out = amp_q;
            if (timer_tc) begin
               if (abort) begin
                  state_d = S_IDLE;
               end else if (idx_q == LAST_IDX) begin
                  train_done = 1'b1;
                  state_d    = (REFRACT_CYCLES > 0) ? S_REFRACT : S_IDLE;
               end else if (period_done) begin
                  state_d    = S_CATH;
                  next_pulse = 1'b1;
               end else begin
                  state_d = S_REST;
               end
            end
         end
         S_REST: begin
            if (en) begin
               state_d = S_IDLE;
            end else if (period_done) begin
               state_d    = S_CATH;
               next_pulse = 1'b1;
            end
         end
         S_REFRACT: begin
            if (en || timer_tc) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Phase/gap/refractory down-counter, reloaded on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q <= '0;
      end else if (state_d != state_q) begin
         case (state_d)
            S_CATH, S_ANOD: timer_q <= PHASE_LD;
            S_GAP:          timer_q <= GAP_LD;
            S_REFRACT:      timer_q <= REFR_LD;
            default:        timer_q <= '0;
         endcase
      end else if (!timer_tc) begin
         timer_q <= timer_q - TW'(1);
      end
   end

   // Period counter: restarts at each cathodic start, saturates instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_q <= '0;
      end else if (state_d == S_CATH && state_q != S_CATH) begin
         period_q <= '0;
      end else if (period_q != '1) begin
         period_q <= period_q + PW'(1);
      end
   end

   // Train bookkeeping: amplitude latch, pulse index and pending-disable flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         amp_q  <= '0;
         idx_q  <= '0;
         stop_q <= 1'b0;
      end else begin
         if (start_train) begin
            amp_q <= amp_in;
            idx_q <= '0;
         end else if (next_pulse) begin
            idx_q <= idx_q + 8'd1;
         end
         if (state_d == S_IDLE)
            stop_q <= 1'b0;
         else if (en && (state_q == S_CATH || state_q == S_GAP || state_q == S_ANOD))
            stop_q <= 1'b1;
      end
   end

   assign pulse_idx = idx_q;

`ifdef STIM_TRAIN_LIMIT_EN
   logic [7:0] train_cnt_q;

   // Completed-train counter; saturating, cleared only by rst.
   always_ff @(posedge clk) begin
      if (rst)                                  train_cnt_q <= '0;
      else if (train_done && train_cnt_q != 8'hFF) train_cnt_q <= train_cnt_q + 8'd1;
   end

   assign lockout = (train_cnt_q >= 8'(MAX_TRAINS));
`else
   assign lockout = 1'b0;
`endif

endmodule
